// File: rtl/cpu_gen2_pkg.sv
// ============================================================================
// Module   : cpu_gen2_pkg
// Brief    : Shared opcodes, FSM step encoding and register-index width helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cpu_gen2_pkg;

   localparam logic [2:0] c_op_mv   = 3'b000;
   localparam logic [2:0] c_op_mvi  = 3'b001;
   localparam logic [2:0] c_op_add  = 3'b010;
   localparam logic [2:0] c_op_sub  = 3'b011;
   localparam logic [2:0] c_op_and  = 3'b100;
   localparam logic [2:0] c_op_or   = 3'b101;
   localparam logic [2:0] c_op_mvnz = 3'b110;
   localparam logic [2:0] c_op_nop  = 3'b111;

   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } state_t;

   // Bits needed to index n registers (n a power of two, up to 16).
   function automatic int calc_rw(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 5; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_gen2_alu.sv
// ============================================================================
// Module   : cpu_gen2_alu
// Brief    : A/G accumulator pair with zero flag; AND/OR only with
//            CPU_GEN2_LOGIC_EN defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cpu_gen2_alu
   import cpu_gen2_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_load,
   input  logic              g_load,
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] bus_in,
   output logic [DATA_W-1:0] g_out,
   output logic              zero
);

   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_g;
   logic              r_zero;
   logic [DATA_W-1:0] w_result;

   always_comb begin
      w_result = r_a + bus_in;
      case (op)
         c_op_sub: w_result = r_a - bus_in;
`ifdef CPU_GEN2_LOGIC_EN
         c_op_and: w_result = r_a & bus_in;
         c_op_or:  w_result = r_a | bus_in;
`endif
         default:  ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a    <= '0;
         r_g    <= '0;
         r_zero <= 1'b0;
      end else begin
         if (a_load) r_a <= bus_in;
         if (g_load) begin
            r_g    <= w_result;
            r_zero <= (w_result == '0);
         end
      end
   end

   assign g_out = r_g;
   assign zero  = r_zero;

endmodule

`default_nettype wire

// File: rtl/cpu_gen2.sv
// ============================================================================
// Module   : cpu_gen2
// Brief    : Multi-cycle bus CPU (T0 fetch, T1..T3 execute). Define
//            CPU_GEN2_LOGIC_EN to enable AND/OR; otherwise they act as NOP.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cpu_gen2
   import cpu_gen2_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic [DATA_W-1:0] din,
   output logic              done,
   output logic              busy,
   output logic              zero,
   output logic [DATA_W-1:0] bus_dbg
);

   localparam int RW   = calc_rw(NUM_REGS);
   localparam int IR_W = 3 + 2 * RW;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [IR_W-1:0]   r_ir;
   logic [2:0]        w_op;
   logic [RW-1:0]     w_rx;
   logic [RW-1:0]     w_ry;
   logic [DATA_W-1:0] r_regs [NUM_REGS];
   logic [NUM_REGS-1:0] w_wr_en;
   logic [DATA_W-1:0] w_bus;
   logic [DATA_W-1:0] w_g;

   logic              w_is_alu;
   logic              w_ir_load;
   logic              w_din_out;
   logic              w_g_out;
   logic              w_rsel_en;
   logic [RW-1:0]     w_rsel;
   logic              w_reg_wr;
   logic              w_a_load;
   logic              w_g_load;
   logic              w_done;

   assign w_op = r_ir[IR_W-1 -: 3];
   assign w_rx = r_ir[2*RW-1 -: RW];
   assign w_ry = r_ir[RW-1:0];

   always_comb begin
      w_is_alu = 1'b0;
      case (w_op)
         c_op_add, c_op_sub: w_is_alu = 1'b1;
`ifdef CPU_GEN2_LOGIC_EN
         c_op_and, c_op_or:  w_is_alu = 1'b1;
`endif
         default:            w_is_alu = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= T0;
         r_ir    <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_ir_load) r_ir <= din[IR_W-1:0];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ir_load   = 1'b0;
      w_din_out   = 1'b0;
      w_g_out     = 1'b0;
      w_rsel_en   = 1'b0;
      w_rsel      = w_ry;
      w_reg_wr    = 1'b0;
      w_a_load    = 1'b0;
      w_g_load    = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         T0: begin
            w_din_out = 1'b1;
            if (run) begin
               w_ir_load   = 1'b1;
               w_state_nxt = T1;
            end
         end
         T1: begin
            if (w_is_alu) begin
               w_rsel_en   = 1'b1;
               w_rsel      = w_rx;
               w_a_load    = 1'b1;
               w_state_nxt = T2;
            end else begin
               w_done      = 1'b1;
               w_state_nxt = T0;
               case (w_op)
                  c_op_mv: begin
                     w_rsel_en = 1'b1;
                     w_reg_wr  = 1'b1;
                  end
                  c_op_mvi: begin
                     w_din_out = 1'b1;
                     w_reg_wr  = 1'b1;
                  end
                  c_op_mvnz: begin
                     w_rsel_en = 1'b1;
                     w_reg_wr  = ~zero;
                  end
                  default: ;
               endcase
            end
         end
         T2: begin
            w_rsel_en   = 1'b1;
            w_g_load    = 1'b1;
            w_state_nxt = T3;
         end
         T3: begin
            w_g_out     = 1'b1;
            w_reg_wr    = 1'b1;
            w_done      = 1'b1;
            w_state_nxt = T0;
         end
         default: w_state_nxt = T0;
      endcase
   end

   // Priority: din, then G, then the selected register; idle bus shows R0.
   always_comb begin
      if (w_din_out)      w_bus = din;
      else if (w_g_out)   w_bus = w_g;
      else if (w_rsel_en) w_bus = r_regs[w_rsel];
      else                w_bus = r_regs[0];
   end

   always_comb begin
      w_wr_en = '0;
      if (w_reg_wr) w_wr_en[w_rx] = 1'b1;
   end

   generate
      for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
         always_ff @(posedge clk or posedge reset) begin
            if (reset)           r_regs[i] <= '0;
            else if (w_wr_en[i]) r_regs[i] <= w_bus;
         end
      end
   endgenerate

   cpu_gen2_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .clk    (clk),
      .reset  (reset),
      .a_load (w_a_load),
      .g_load (w_g_load),
      .op     (w_op),
      .bus_in (w_bus),
      .g_out  (w_g),
      .zero   (zero)
   );

   assign done    = w_done;
   assign busy    = (r_state != T0);
   assign bus_dbg = w_bus;

endmodule

`default_nettype wire

// File: tb/tb_cpu_gen2.sv
// ============================================================================
// Module   : tb_cpu_gen2
// Brief    : Self-checking bench for cpu_gen2 (honours CPU_GEN2_LOGIC_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cpu_gen2;

   localparam logic [2:0] OP_MV = 3'd0, OP_MVI = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3;
   localparam logic [2:0] OP_AND = 3'd4, OP_OR = 3'd5, OP_MVNZ = 3'd6, OP_NOP = 3'd7;
`ifdef CPU_GEN2_LOGIC_EN
   localparam bit LOGIC_EN = 1'b1;
`else
   localparam bit LOGIC_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        run = 1'b0;
   logic [15:0] din = '0;
   logic        done, busy, zero;
   logic [15:0] bus_dbg;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] m_regs [8];
   logic        m_zero;

   cpu_gen2 #(.DATA_W(16), .NUM_REGS(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .run     (run),
      .din     (din),
      .done    (done),
      .busy    (busy),
      .zero    (zero),
      .bus_dbg (bus_dbg)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_zero = 1'b0;
   endtask

   // Issue one instruction from a T0 negedge; returns at the next T0 negedge.
   task automatic exec(input logic [2:0] op, input int rx, input int ry, input logic [15:0] imm,
                       output int lat, output logic [15:0] bus_seen);
      int          exp_lat;
      logic [15:0] exp_bus, res, w;
      bit          bus_valid;
      logic [31:0] sw;
      exp_lat = 1; bus_valid = 1'b1; exp_bus = m_regs[0];
      if (op == OP_MV) begin
         exp_bus = m_regs[ry]; m_regs[rx] = m_regs[ry];
      end else if (op == OP_MVI) begin
         exp_bus = imm; m_regs[rx] = imm;
      end else if (op == OP_MVNZ) begin
         exp_bus = m_regs[ry];
         if (!m_zero) m_regs[rx] = m_regs[ry];
         else bus_valid = 1'b0;
      end else if (op == OP_ADD || op == OP_SUB || (LOGIC_EN && (op == OP_AND || op == OP_OR))) begin
         case (op)
            OP_ADD:  res = m_regs[rx] + m_regs[ry];
            OP_SUB:  res = m_regs[rx] - m_regs[ry];
            OP_AND:  res = m_regs[rx] & m_regs[ry];
            default: res = m_regs[rx] | m_regs[ry];
         endcase
         exp_lat = 3; exp_bus = res; m_zero = (res == 16'd0); m_regs[rx] = res;
      end
      sw = $urandom;
      w = sw[15:0];
      w[8:0] = {op, rx[2:0], ry[2:0]};
      din = w; run = 1'b1;
      @(posedge clk);
      lat = 0; bus_seen = 'x;
      for (int c = 1; c <= 4 && lat == 0; c++) begin
         @(negedge clk);
         if (c == 1) begin run = 1'b0; din = imm; end
         #1;
         check("busy_exec", busy, 1);
         if (done) begin lat = c; bus_seen = bus_dbg; end
         else @(posedge clk);
      end
      check("latency", lat, exp_lat);
      if (bus_valid) check("bus_at_done", bus_seen, exp_bus);
      @(posedge clk);
      @(negedge clk);
      check("zero_after", zero, m_zero);
      check("idle_busy", busy, 0);
   endtask

   task automatic read_reg(input int r, output logic [15:0] val);
      int          lat;
      logic [31:0] sw;
      sw = $urandom;
      exec(OP_MV, r, r, sw[15:0], lat, val);
   endtask

   task automatic check_all_regs(input string name);
      logic [15:0] v;
      for (int r = 0; r < 8; r++) begin
         read_reg(r, v);
         check(name, v, m_regs[r]);
      end
   endtask

   typedef struct {
      logic [2:0]  op;
      int          rx;
      int          ry;
      logic [15:0] imm;
      int          lat;
      logic [15:0] val;
      logic        z;
   } vec_t;

   vec_t vecs [16];

   initial begin
      int          lat, cnt;
      logic [15:0] v, imm;
      logic [31:0] sw;
      logic [2:0]  op;

      vecs[0]  = '{OP_MVI,  0, 0, 16'h0005, 1, 16'h0005, 1'b0};
      vecs[1]  = '{OP_MVI,  1, 0, 16'h0003, 1, 16'h0003, 1'b0};
      vecs[2]  = '{OP_ADD,  0, 1, 16'h0000, 3, 16'h0008, 1'b0};
      vecs[3]  = '{OP_MVI,  2, 0, 16'h0000, 1, 16'h0000, 1'b0};
      vecs[4]  = '{OP_MVI,  3, 0, 16'h0001, 1, 16'h0001, 1'b0};
      vecs[5]  = '{OP_SUB,  2, 3, 16'h0000, 3, 16'hFFFF, 1'b0};
      vecs[6]  = '{OP_SUB,  2, 2, 16'h0000, 3, 16'h0000, 1'b1};
      vecs[7]  = '{OP_MVI,  4, 0, 16'h1234, 1, 16'h1234, 1'b1};
      vecs[8]  = '{OP_MVNZ, 4, 3, 16'h0000, 1, 16'h1234, 1'b1};
      vecs[9]  = '{OP_ADD,  1, 1, 16'h0000, 3, 16'h0006, 1'b0};
      vecs[10] = '{OP_MVNZ, 5, 1, 16'h0000, 1, 16'h0006, 1'b0};
      vecs[11] = '{OP_MV,   6, 0, 16'hBEEF, 1, 16'h0008, 1'b0};
      vecs[12] = '{OP_NOP,  6, 2, 16'hBEEF, 1, 16'h0008, 1'b0};
`ifdef CPU_GEN2_LOGIC_EN
      vecs[13] = '{OP_AND,  0, 1, 16'h0000, 3, 16'h0000, 1'b1};
`else
      vecs[13] = '{OP_AND,  0, 1, 16'h0000, 1, 16'h0008, 1'b0};
`endif
      vecs[14] = '{OP_OR,   3, 0, 16'h0000, (LOGIC_EN ? 3 : 1), 16'h0001, 1'b0};
      vecs[15] = '{OP_ADD,  7, 7, 16'h0000, 3, 16'h0000, 1'b1};

      // Reset state
      model_clear();
      din = 16'h5A5A;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_zero", zero, 0);
      check("rst_bus_din", bus_dbg, 16'h5A5A);
      reset = 1'b0;
      @(negedge clk);
      check_all_regs("rst_regs");

      // Directed table
      foreach (vecs[i]) begin
         exec(vecs[i].op, vecs[i].rx, vecs[i].ry, vecs[i].imm, lat, v);
         check("tbl_lat", lat, vecs[i].lat);
         read_reg(vecs[i].rx, v);
         check("tbl_val", v, vecs[i].val);
         check("tbl_zero", zero, vecs[i].z);
      end

      // Idle in T0 after a single run pulse
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("idle_busy_hold", busy, 0);
         check("idle_done_hold", done, 0);
      end

      // Back-to-back with run held: done every other cycle
      din = {7'd0, OP_MV, 3'd6, 3'd6};
      run = 1'b1;
      cnt = 0;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) cnt++;
         if (c == 1) check("b2b_first_done", done, 1);
      end
      run = 1'b0;
      check("b2b_done_count", cnt, 4);
      @(negedge clk);
      check("b2b_busy_end", busy, 0);

      // Reset in T2 of an ADD
      din = {7'd0, OP_ADD, 3'd0, 3'd1};
      run = 1'b1;
      @(posedge clk);
      @(negedge clk);
      run = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("t2_busy_before", busy, 1);
      reset = 1'b1;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_zero", zero, 0);
      @(posedge clk);
      @(negedge clk);
      check("midrst_done_hold", done, 0);
      model_clear();
      reset = 1'b0;
      @(negedge clk);
      check_all_regs("midrst_regs");

      // First fetch on the first rising edge after release
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      model_clear();
      reset = 1'b0;
      run   = 1'b1;
      din   = {7'd0, OP_MVI, 3'd7, 3'd0};
      @(posedge clk);
      @(negedge clk);
      run = 1'b0;
      din = 16'h00AA;
      #1;
      check("rel_fetch_done", done, 1);
      check("rel_fetch_bus", bus_dbg, 16'h00AA);
      m_regs[7] = 16'h00AA;
      @(posedge clk);
      @(negedge clk);
      read_reg(7, v);
      check("rel_fetch_r7", v, 16'h00AA);

      // Randomised instructions against the reference model
      for (int n = 0; n < 250; n++) begin
         sw = $urandom;
         op = sw[2:0];
         case (sw[5:4])
            2'd0:    imm = 16'h0000;
            2'd1:    imm = 16'hFFFF;
            default: imm = sw[31:16];
         endcase
         exec(op, int'(sw[8:6]), int'(sw[11:9]), imm, lat, v);
         if (n % 25 == 24) check_all_regs("rand_regs");
      end
      check_all_regs("final_regs");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/cpu_gen2.md
CPU_GEN2 -- requirements
Module: cpu_gen2

Interface
REQ-001 Parameter DATA_W, 16, datapath, bus, register and ALU width in bits (>= 8).
REQ-002 Parameter NUM_REGS, 8, number of general registers (power of two, 2..16); RW = log2(NUM_REGS).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port run  input  1  start request; sampled only in state T0.
REQ-006 Port din  input  DATA_W  instruction word in T0, immediate word in T1 (MVI).
REQ-007 Port done  output  1  one-cycle pulse in the final step of each instruction.
REQ-008 Port busy  output  1  high in T1..T3.
REQ-009 Port zero  output  1  registered flag, set when the last value written to G is 0.
REQ-010 Port bus_dbg  output  DATA_W  current internal bus value, combinational.

Function
REQ-011 Instruction layout SHALL be IR = din[3+2*RW-1:0]: opcode[2:0] in MSBs, then Rx (RW bits), then Ry (RW bits); the remaining din bits are ignored.
REQ-012 Opcodes: 000 MV, 001 MVI, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 MVNZ, 111 NOP.
REQ-013 The FSM states SHALL be T0 (fetch), T1, T2 and T3, encoded in the shared package.
REQ-014 In T0 with run=1, IR SHALL load from din and the FSM SHALL go to T1; with run=0 the FSM SHALL stay in T0 and IR SHALL hold.
REQ-015 Once in T1, the instruction SHALL complete regardless of run.
REQ-016 MV: in T1, Rx <= Ry, done=1, then T0.
REQ-017 MVI: in T1, Rx <= din, done=1, then T0.
REQ-018 MVNZ: in T1, if zero=0 then Rx <= Ry, else no register write; done=1, then T0.
REQ-019 NOP: done=1 in T1, no writes, then T0.
REQ-020 ADD/SUB/AND/OR: T1 A <= Ry... no — T1 A <= Rx; T2 G <= A op Ry and zero <= (result==0); T3 Rx <= G, done=1, then T0.
REQ-021 ADD and SUB arithmetic SHALL be modulo 2^DATA_W; no carry is kept.
REQ-022 Bus priority SHALL be din (fetch/MVI) > G (T3) > selected register; when nothing drives it, the bus SHALL show R0.
REQ-023 Rx==Ry SHALL be legal; for ADD R1,R1 the result is 2*R1 mod 2^DATA_W.
REQ-024 The minimum instruction latency from a T0 fetch to done SHALL be 1 cycle (MV/MVI/MVNZ/NOP) or 3 cycles (ALU ops).
REQ-025 run held high SHALL execute back-to-back instructions with no idle cycle between done and the next T0 fetch.

Reset
REQ-026 reset=1 SHALL asynchronously clear all registers, A, G, IR, zero and the FSM (to T0), including in the middle of an instruction.
REQ-027 While reset=1 and at release, done and busy SHALL be 0 and no register write SHALL occur.
REQ-028 The first fetch SHALL happen on the first rising edge after release with run=1.

Configuration
REQ-029 Macro CPU_GEN2_LOGIC_EN defined: AND and OR execute as in REQ-020.
REQ-030 Macro CPU_GEN2_LOGIC_EN undefined: opcodes 100/101 SHALL behave exactly as NOP, leaving A, G and zero unchanged, and no logic gates SHALL be synthesised.

Structure
REQ-031 The shared package cpu_gen2_pkg SHALL hold the opcode constants, the FSM state encoding and an RW computation function.
REQ-032 The ALU (A, G, zero flag and op select) SHALL be one sub-module, cpu_gen2_alu, parametrised by DATA_W.
REQ-033 The register file SHALL be an array of NUM_REGS words with a one-hot write enable decoded from Rx.

Verification
REQ-034 Defaults: reset, then MVI R0,0x0005 and MVI R1,0x0003, then ADD R0,R1 -> R0=0x0008, zero=0, done after 3 cycles.
REQ-035 R2=0x0000, R3=0x0001, SUB R2,R3 -> R2=0xFFFF (wrap-around); then SUB R2,R2 -> zero=1, and a following MVNZ R4,R3 leaves R4 unchanged.
REQ-036 run pulsed for one cycle with ADD -> full 3-cycle completion; run=0 afterwards -> FSM idles in T0 and busy=0.
REQ-037 reset asserted in T2 of an ADD -> all registers 0, state T0, no done pulse.
REQ-038 DATA_W=8, NUM_REGS=4, LOGIC_EN undefined: MVI R3,0xF0; MVI R2,0x0F; AND R3,R2 -> R3 stays 0xF0, done in T1.
